// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared types and constants for the memory-stage controller:
//            controller state encoding, default wait count and the width of
//            the wait counter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Default number of idle ACCESS cycles before the memory strobe
    localparam int c_wait_cycles_def = 2;

    // Width of the loadable wait counter (covers WAIT_CYCLES 0..15)
    localparam int c_cnt_width = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_cnt
// Brief    : Loadable down-counter that saturates at zero. Flags zero so the
//            controller knows when the wait phase is over.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_cnt
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = c_cnt_width
) (
    input  logic             clk,
    input  logic             rst,     // active-low, asynchronous
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down while enabled and nonzero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : mem_wait_cnt
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : Pipeline memory-stage controller. Accepts one load/store at a
//            time, waits WAIT_CYCLES idle cycles, issues a single strobe to a
//            combinational-read word memory and returns a one-cycle response.
//            Optional macro MEM_STAGE_ALIGN_CHECK_EN: when defined, odd byte
//            addresses are rejected with rsp_err and never reach memory; when
//            undefined, address bit 0 is dropped and rsp_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = c_wait_cycles_def
) (
    input  logic                  clk,
    input  logic                  rst,          // active-low, asynchronous
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    localparam logic [c_cnt_width-1:0] c_wait_load = c_cnt_width'(WAIT_CYCLES);
    // Word addressing: byte-address bit 0 never reaches the memory
    localparam logic [ADDR_WIDTH-1:0]  c_word_mask = ~ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_strobe;
    logic                  w_misalign;
    logic                  w_zero;
    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_rdata;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misalign = req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    mem_wait_cnt #(
        .WIDTH (c_cnt_width)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (w_cnt_load),
        .value (c_wait_load),
        .dec   (w_cnt_dec),
        .zero  (w_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; ready is masked while reset is held
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_strobe   = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        req_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = rst;
                w_accept  = req_valid & rst;
                if (w_accept) begin
                    if (w_misalign) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_ACCESS;
                        w_cnt_load = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_zero) begin
                    w_strobe = 1'b1;
                    w_next   = ST_RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request capture so later req_* activity cannot disturb the transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic r_err;

    // Response data/error, updated only on the way into RESP and held after
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_strobe) begin
            r_rdata <= r_wr ? 16'h0000 : mem_data_out;
            r_err   <= 1'b0;
        end else if (w_accept && w_misalign) begin
            r_rdata <= 16'h0000;
            r_err   <= 1'b1;
        end
    end

    assign rsp_err = r_err;
`else
    // Response data, updated only on the way into RESP and held after
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_strobe) begin
            r_rdata <= r_wr ? 16'h0000 : mem_data_out;
        end
    end

    assign rsp_err = 1'b0;
`endif

    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rdata;
    assign mem_enable  = w_strobe;
    assign mem_wr      = w_strobe & r_wr;
    assign mem_data_in = w_strobe ? r_wdata : 16'h0000;
    assign mem_addr    = r_addr & c_word_mask;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Self-checking bench for mem_stage_ctrl. Two lanes run in
//            parallel: WAIT_CYCLES=2 and WAIT_CYCLES=0. Each lane has a word
//            memory, a transaction-level timing model and directed plus
//            random stimulus. Works with or without MEM_STAGE_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit lane_done [2];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    localparam bit c_align = 1'b1;
`else
    localparam bit c_align = 1'b0;
`endif

    // Cycle index: cycle n is the period following rising edge n
    always @(posedge clk) cyc <= cyc + 1;

    // Power-up memory contents
    function automatic logic [15:0] mem_init(input int idx);
        if (idx == 8)  return 16'hBEEF;   // byte address 0x0010
        if (idx == 24) return 16'h5A5A;   // byte address 0x0030
        return {8'hA0, 8'(idx)};
    endfunction

    task automatic chk(input int lane, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane, nm, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int W          = (g == 0) ? 2 : 0;
        localparam int LIT_STROBE = (g == 0) ? 3 : 1;   // hand-derived latency
        localparam int LIT_RSP    = (g == 0) ? 4 : 2;

        logic        rst       = 1'b1;
        logic        req_valid = 1'b0;
        logic        req_wr    = 1'b0;
        logic [15:0] req_addr  = 16'h0;
        logic [15:0] req_wdata = 16'h0;
        logic        req_ready, rsp_valid, rsp_err, mem_enable, mem_wr;
        logic [15:0] rsp_rdata, mem_addr, mem_data_in, mem_data_out;

        logic [15:0] mem      [64];
        bit          mem_flag [64];
        bit          mem_clr = 1'b1;

        int          obs_acc, obs_strobe_cyc, obs_rsp_cyc;
        int          strobe_cnt = 0;
        int          wr_cnt     = 0;
        logic [15:0] obs_strobe_addr, obs_rdata;
        logic        obs_err;

        mem_stage_ctrl #(
            .ADDR_WIDTH  (16),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_ready    (req_ready),
            .req_wr       (req_wr),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .rsp_valid    (rsp_valid),
            .rsp_rdata    (rsp_rdata),
            .rsp_err      (rsp_err),
            .mem_enable   (mem_enable),
            .mem_wr       (mem_wr),
            .mem_addr     (mem_addr),
            .mem_data_in  (mem_data_in),
            .mem_data_out (mem_data_out)
        );

        // Word memory: synchronous write, combinational read
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 64; i++) mem_flag[i] <= 1'b0;
            end else if (mem_enable && mem_wr) begin
                mem[mem_addr[6:1]]      <= mem_data_in;
                mem_flag[mem_addr[6:1]] <= 1'b1;
            end
        end
        assign mem_data_out = mem_flag[mem_addr[6:1]] ? mem[mem_addr[6:1]]
                                                      : mem_init(int'(mem_addr[6:1]));

        // Transaction-level model and per-cycle compare
        initial begin
            logic [15:0] shadow [64];
            bit          busy = 1'b0;
            int          acc  = 0;
            int          r_cyc;
            bit          m_wr = 1'b0, m_mis = 1'b0;
            logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, pend = 16'h0;
            logic [15:0] e_rdata = 16'h0;
            bit          e_err = 1'b0, e_ready, e_strobe, e_valid;
            for (int i = 0; i < 64; i++) shadow[i] = mem_init(i);
            forever begin
                @(negedge clk);
                if (!rst) begin
                    busy = 1'b0; e_rdata = 16'h0; e_err = 1'b0;
                    e_ready = 1'b0; e_strobe = 1'b0; e_valid = 1'b0;
                    chk(g, "reset_mem_addr", 32'(mem_addr), 32'h0);
                end else begin
                    e_ready  = !busy;
                    r_cyc    = m_mis ? acc + 1 : acc + W + 2;
                    e_strobe = busy && !m_mis && (cyc == acc + W + 1);
                    e_valid  = busy && (cyc == r_cyc);
                    if (e_strobe) begin
                        pend = m_wr ? 16'h0 : shadow[m_addr[6:1]];
                        if (m_wr) shadow[m_addr[6:1]] = m_wdata;
                        chk(g, "mem_addr", 32'(mem_addr), 32'(m_addr & 16'hFFFE));
                    end
                    if (e_valid) begin
                        e_rdata = m_mis ? 16'h0 : pend;
                        e_err   = m_mis;
                    end
                end
                chk(g, "req_ready",   32'(req_ready),   32'(e_ready));
                chk(g, "mem_enable",  32'(mem_enable),  32'(e_strobe));
                chk(g, "mem_wr",      32'(mem_wr),      32'(e_strobe && m_wr));
                chk(g, "mem_data_in", 32'(mem_data_in), 32'(e_strobe ? m_wdata : 16'h0));
                chk(g, "rsp_valid",   32'(rsp_valid),   32'(e_valid));
                chk(g, "rsp_rdata",   32'(rsp_rdata),   32'(e_rdata));
                chk(g, "rsp_err",     32'(rsp_err),     32'(e_err));
                if (e_valid) busy = 1'b0;
                if (rst && e_ready && req_valid) begin
                    busy    = 1'b1;
                    acc     = cyc;
                    m_wr    = req_wr;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_mis   = c_align && req_addr[0];
                end
                // Observations for the directed literal checks
                if (req_valid && req_ready) obs_acc = cyc;
                if (mem_enable) begin
                    strobe_cnt++;
                    if (mem_wr) wr_cnt++;
                    obs_strobe_cyc  = cyc;
                    obs_strobe_addr = mem_addr;
                end
                if (rsp_valid) begin
                    obs_rsp_cyc = cyc;
                    obs_rdata   = rsp_rdata;
                    obs_err     = rsp_err;
                end
            end
        end

        task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d);
            bit ok = 1'b0;
            req_wr = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (req_ready) ok = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk(g, "req_accepted", 32'(ok), 32'h1);
        endtask

        task automatic wait_rsp();
            bit ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (rsp_valid) ok = 1'b1;
            end
            @(posedge clk); #1;
            chk(g, "rsp_seen", 32'(ok), 32'h1);
        endtask

        initial begin
            int s0, w0, a1, a2, r1;
            #1 rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk(g, "rst_req_ready", 32'(req_ready), 32'h0);
            chk(g, "rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk(g, "rst_mem_en",    32'(mem_enable), 32'h0);
            chk(g, "rst_rdata",     32'(rsp_rdata), 32'h0);
            mem_clr = 1'b0;
            rst     = 1'b1;
            @(posedge clk); #1;

            // Load of 0x0010 holding 0xBEEF
            s0 = strobe_cnt;
            do_req(1'b0, 16'h0010, 16'h0000);
            wait_rsp();
            chk(g, "ld_strobes",   32'(strobe_cnt - s0), 32'd1);
            chk(g, "ld_strobe_at", 32'(obs_strobe_cyc - obs_acc), 32'(LIT_STROBE));
            chk(g, "ld_rsp_at",    32'(obs_rsp_cyc - obs_acc), 32'(LIT_RSP));
            chk(g, "ld_rdata",     32'(obs_rdata), 32'h0000BEEF);
            chk(g, "ld_err",       32'(obs_err), 32'h0);

            // Store then load back
            w0 = wr_cnt;
            do_req(1'b1, 16'h0020, 16'h1234);
            wait_rsp();
            chk(g, "st_wr_cycles", 32'(wr_cnt - w0), 32'd1);
            chk(g, "st_rdata",     32'(obs_rdata), 32'h0);
            do_req(1'b0, 16'h0020, 16'h0000);
            wait_rsp();
            chk(g, "st_ld_rdata",  32'(obs_rdata), 32'h00001234);

            // Back-to-back requests
            do_req(1'b0, 16'h0010, 16'h0000);
            a1 = obs_acc;
            do_req(1'b0, 16'h0020, 16'h0000);
            a2 = obs_acc;
            r1 = obs_rsp_cyc;
            chk(g, "b2b_strobe_at", 32'(obs_strobe_cyc - a1), 32'(LIT_STROBE));
            chk(g, "b2b_rsp_at",    32'(r1 - a1), 32'(LIT_RSP));
            chk(g, "b2b_next_acc",  32'(a2 - r1), 32'd1);
            wait_rsp();
            chk(g, "b2b_rdata",     32'(obs_rdata), 32'h00001234);

            // Odd address
            s0 = strobe_cnt;
            do_req(1'b0, 16'h0011, 16'h0000);
            wait_rsp();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            chk(g, "mis_strobes", 32'(strobe_cnt - s0), 32'd0);
            chk(g, "mis_rsp_at",  32'(obs_rsp_cyc - obs_acc), 32'd1);
            chk(g, "mis_err",     32'(obs_err), 32'h1);
            chk(g, "mis_rdata",   32'(obs_rdata), 32'h0);
`else
            chk(g, "odd_strobes", 32'(strobe_cnt - s0), 32'd1);
            chk(g, "odd_addr",    32'(obs_strobe_addr), 32'h00000010);
            chk(g, "odd_rdata",   32'(obs_rdata), 32'h0000BEEF);
`endif

            // Reset in the first ACCESS cycle of a store
            s0 = strobe_cnt;
            do_req(1'b1, 16'h0030, 16'hDEAD);
            #1 rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "abort_ready", 32'(req_ready), 32'h0);
            chk(g, "abort_rsp",   32'(rsp_valid), 32'h0);
            chk(g, "abort_rdata", 32'(rsp_rdata), 32'h0);
            rst = 1'b1;
            @(negedge clk);
            chk(g, "abort_ready_after", 32'(req_ready), 32'h1);
            @(posedge clk); #1;
            chk(g, "abort_strobes", 32'(strobe_cnt - s0), 32'd0);
            do_req(1'b0, 16'h0030, 16'h0000);
            wait_rsp();
            chk(g, "abort_mem_kept", 32'(obs_rdata), 32'h00005A5A);

            // Requests toggled while busy are ignored
            s0 = strobe_cnt;
            do_req(1'b0, 16'h0040, 16'h0000);
            a1 = obs_acc;
            for (int k = 0; k < W + 2; k++) begin
                req_valid = (k % 2 == 0);
                req_wr    = 1'b1;
                req_addr  = 16'h0050 + 16'(2 * k);
                req_wdata = 16'hFFFF;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            chk(g, "busy_strobes", 32'(strobe_cnt - s0), 32'd1);
            chk(g, "busy_addr",    32'(obs_strobe_addr), 32'h00000040);
            chk(g, "busy_rsp_at",  32'(obs_rsp_cyc - a1), 32'(LIT_RSP));
            chk(g, "busy_rdata",   32'(obs_rdata), 32'h0000A020);

            // Random traffic with occasional resets
            for (int k = 0; k < 400; k++) begin
                if (rst && $urandom_range(0, 79) == 0) rst = 1'b0;
                else rst = 1'b1;
                req_valid = ($urandom_range(0, 3) != 0);
                req_wr    = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom_range(0, 127));
                req_wdata = 16'($urandom);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            rst       = 1'b1;
            repeat (10) @(posedge clk);
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 5000 && !(lane_done[0] && lane_done[1]); i++) @(posedge clk);
        chk(-1, "all_lanes_done", 32'(lane_done[0] && lane_done[1]), 32'h1);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory byte-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, idle cycles inserted before the memory strobe (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  pipeline request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata  input  16  store data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  misaligned access flag, qualified by rsp_valid.
REQ-013 SHALL have ports mem_enable, mem_wr (output, 1), mem_addr (output, ADDR_WIDTH), mem_data_in (output, 16) and mem_data_out (input, 16), which drive the word memory.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-016 SHALL latch req_wr, req_addr and req_wdata on acceptance; the outputs SHALL NOT depend on the req_* inputs after acceptance.
REQ-017 SHALL move an aligned acceptance IDLE->ACCESS and load wait counter = WAIT_CYCLES.
REQ-018 SHALL decrement the counter each ACCESS cycle while it is nonzero; mem_enable=1 only in the ACCESS cycle with counter==0, so there is exactly one strobe per request.
REQ-019 SHALL drive mem_wr = latched req_wr, mem_addr = latched addr and mem_data_in = latched wdata during the strobe cycle; mem_enable, mem_wr and mem_data_in SHALL be 0 in every other cycle.
REQ-020 SHALL, for a load, capture mem_data_out into rsp_rdata at the end of the strobe cycle; the memory read is combinational.
REQ-021 SHALL go ACCESS->RESP after the strobe cycle, and RESP->IDLE unconditionally after one cycle; there is no response backpressure.
REQ-022 SHALL give latency: rsp_valid high exactly WAIT_CYCLES+2 cycles after the acceptance edge, for one cycle.
REQ-023 SHALL hold rsp_rdata and rsp_err stable from RESP until the next RESP; a new request may be accepted in the cycle after RESP.
REQ-024 SHALL, when req_valid is asserted outside IDLE, ignore it; the source holds the request until it sees ready.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, and all mem_* outputs 0; the effect is immediate (asynchronous).
REQ-026 SHALL abort an in-flight request on reset mid-ACCESS with no strobe issued; after release, req_ready=1 in the first cycle.

Configuration
REQ-027 SHALL, with MEM_STAGE_ALIGN_CHECK_EN defined, treat an accepted request with req_addr[0]=1 as a misaligned access: go IDLE->RESP directly, issue no strobe, and return rsp_err=1 and rsp_rdata=0.
REQ-028 SHALL, without MEM_STAGE_ALIGN_CHECK_EN, force mem_addr[0]=0, process misaligned requests normally, and tie rsp_err to 0.

Structure
REQ-029 SHALL place the FSM state enum, the default WAIT_CYCLES constant and the counter width (4) in shared package mem_stage_pkg.
REQ-030 SHALL implement the loadable down-counter as sub-module mem_wait_cnt (inputs: load, value; output: zero flag).

Verification
REQ-031 SHALL cover a load with WAIT_CYCLES=2 at addr 0x0010 where memory holds 0xBEEF -> one strobe 3 cycles after acceptance, rsp_valid 4 cycles after, rsp_rdata=0xBEEF, rsp_err=0.
REQ-032 SHALL cover a store of 0x1234 to 0x0020 followed by a load of 0x0020 -> exactly one mem_wr=1 cycle, and the load returns 0x1234.
REQ-033 SHALL cover WAIT_CYCLES=0 with back-to-back requests -> strobe in the first cycle after acceptance, rsp_valid 2 cycles after acceptance, next acceptance in the cycle after RESP.
REQ-034 SHALL cover a load of 0x0011 with MEM_STAGE_ALIGN_CHECK_EN defined -> no mem_enable, rsp_valid 1 cycle after acceptance, rsp_err=1, rsp_rdata=0; without the macro -> a strobe on 0x0010.
REQ-035 SHALL cover rst asserted in the first ACCESS cycle of a store -> mem_enable never asserted, memory unchanged, outputs 0, and req_ready=1 after release.
REQ-036 SHALL cover req_valid toggled with new addresses during ACCESS -> ignored, and the latched address is still used on the strobe.
